// File: rtl/burst_addr_gen_if.sv
// -----------------------------------------------------------------------------
// burst_addr_gen_if
// Command and per-beat address bundle for burst_addr_gen.
//
// Signals
//   cmd_valid / cmd_ready   command handshake (source -> generator)
//   cmd_addr                burst start address
//   cmd_len                 beats in burst (0 treated as 1, >MAX clamped)
//   cmd_mode                00 FIXED, 01 INCR, 10 WRAP, 11 INCR
//   cmd_stride              address step per beat, bytes
//   addr_valid / addr_ready beat handshake (generator -> consumer)
//   addr_out                current beat address
//   addr_last               final beat of the burst
//   beat_idx                0-based beat index
//   busy                    burst in progress
//
// Modports
//   slave   the generator itself
//   master  the command source / beat consumer side
// -----------------------------------------------------------------------------
interface burst_addr_gen_if #(
    parameter int ADDR_WIDTH    = 32,
    parameter int MAX_BURST_LEN = 16,
    parameter int STRIDE_WIDTH  = 8
);
    localparam int LEN_WIDTH = $clog2(MAX_BURST_LEN) + 1;

    logic                    cmd_valid;
    logic                    cmd_ready;
    logic [ADDR_WIDTH-1:0]   cmd_addr;
    logic [LEN_WIDTH-1:0]    cmd_len;
    logic [1:0]              cmd_mode;
    logic [STRIDE_WIDTH-1:0] cmd_stride;

    logic                    addr_valid;
    logic                    addr_ready;
    logic [ADDR_WIDTH-1:0]   addr_out;
    logic                    addr_last;
    logic [LEN_WIDTH-1:0]    beat_idx;
    logic                    busy;

    modport slave (
        input  cmd_valid, cmd_addr, cmd_len, cmd_mode, cmd_stride, addr_ready,
        output cmd_ready, addr_valid, addr_out, addr_last, beat_idx, busy
    );

    modport master (
        output cmd_valid, cmd_addr, cmd_len, cmd_mode, cmd_stride, addr_ready,
        input  cmd_ready, addr_valid, addr_out, addr_last, beat_idx, busy
    );
endinterface

// File: rtl/burst_addr_gen.sv
// -----------------------------------------------------------------------------
// burst_addr_gen
// Accepts one burst command and emits one address per beat in FIXED, INCR or
// WRAP mode. Commands and beats never overlap: the next command is accepted
// only once the generator is back in IDLE.
//
// Ports
//   clk            clock, all logic on posedge
//   rst            synchronous reset, active-high
//   bus            burst_addr_gen_if.slave (command and beat handshakes)
//   dbg_burst_cnt  [15:0] completed bursts, saturating   (debug build only)
//   dbg_err        sticky illegal-command flag           (debug build only)
//
// Configuration
//   BURST_ADDR_GEN_DEBUG_EN  when defined, adds dbg_burst_cnt and dbg_err.
//   The address datapath is identical with or without it.
//
// States
//   state   | meaning
//   S_IDLE  | waiting for a command, cmd_ready=1
//   S_BURST | emitting beats, addr_valid=1, busy=1
// -----------------------------------------------------------------------------
module burst_addr_gen #(
    parameter int ADDR_WIDTH    = 32,
    parameter int MAX_BURST_LEN = 16,
    parameter int STRIDE_WIDTH  = 8
) (
    input  logic clk,
    input  logic rst,
    burst_addr_gen_if.slave bus
`ifdef BURST_ADDR_GEN_DEBUG_EN
    ,
    output logic [15:0] dbg_burst_cnt,
    output logic        dbg_err
`endif
);
    localparam int LEN_WIDTH = $clog2(MAX_BURST_LEN) + 1;
    localparam logic [LEN_WIDTH-1:0]  MAX_LEN  = LEN_WIDTH'(MAX_BURST_LEN);
    localparam logic [LEN_WIDTH-1:0]  ONE_LEN  = LEN_WIDTH'(1);
    localparam logic [ADDR_WIDTH-1:0] ONE_ADDR = ADDR_WIDTH'(1);

    typedef enum logic {S_IDLE, S_BURST} state_t;
    typedef enum logic [1:0] {M_FIXED = 2'b00, M_INCR = 2'b01, M_WRAP = 2'b10} step_t;

    state_t state, state_nxt;

    // Latched burst context
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [ADDR_WIDTH-1:0] base_q;
    logic [ADDR_WIDTH-1:0] mask_q;
    logic [ADDR_WIDTH-1:0] stride_q;
    logic [LEN_WIDTH-1:0]  len_q;
    logic [LEN_WIDTH-1:0]  idx_q;
    step_t                 step_q;

    // Command decode
    logic [LEN_WIDTH-1:0]  len_eff;
    logic [ADDR_WIDTH-1:0] stride_ext;
    logic [ADDR_WIDTH-1:0] span;
    logic [ADDR_WIDTH-1:0] wrap_mask;
    logic                  len_pow2;
    logic                  stride_pow2;
    logic                  wrap_ok;
    step_t                 step_sel;

    logic [ADDR_WIDTH-1:0] addr_sum;
    logic [ADDR_WIDTH-1:0] addr_next;
    logic                  is_last;
    logic                  cmd_fire;
    logic                  beat_fire;

    always_comb begin
        stride_ext = ADDR_WIDTH'(bus.cmd_stride);

        if (bus.cmd_len == '0) begin
            len_eff = ONE_LEN;
        end else if (bus.cmd_len > MAX_LEN) begin
            len_eff = MAX_LEN;
        end else begin
            len_eff = bus.cmd_len;
        end

        len_pow2    = ((len_eff & (len_eff - ONE_LEN)) == '0);
        stride_pow2 = (stride_ext != '0) && ((stride_ext & (stride_ext - ONE_ADDR)) == '0);
        wrap_ok     = len_pow2 && stride_pow2;

        // Both factors are powers of two, so span is one too; if it overflows
        // to zero the mask becomes all-ones and the wrap covers the whole space.
        span      = ADDR_WIDTH'(len_eff) * stride_ext;
        wrap_mask = span - ONE_ADDR;

        case (bus.cmd_mode)
            2'b00:   step_sel = M_FIXED;
            2'b10:   step_sel = wrap_ok ? M_WRAP : M_INCR;
            default: step_sel = M_INCR;
        endcase
    end

    // Stride 0 needs no special case: addr + 0 keeps the address fixed.
    always_comb begin
        addr_sum = addr_q + stride_q;
        case (step_q)
            M_FIXED: addr_next = addr_q;
            M_WRAP:  addr_next = base_q | (addr_sum & mask_q);
            default: addr_next = addr_sum;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        cmd_fire       = 1'b0;
        beat_fire      = 1'b0;
        is_last        = 1'b0;
        bus.cmd_ready  = 1'b0;
        bus.addr_valid = 1'b0;
        bus.busy       = 1'b0;
        bus.addr_last  = 1'b0;

        case (state)
            S_IDLE: begin
                bus.cmd_ready = 1'b1;
                if (bus.cmd_valid) begin
                    cmd_fire  = 1'b1;
                    state_nxt = S_BURST;
                end
            end
            S_BURST: begin
                bus.addr_valid = 1'b1;
                bus.busy       = 1'b1;
                is_last        = (idx_q == (len_q - ONE_LEN));
                bus.addr_last  = is_last;
                if (bus.addr_ready) begin
                    beat_fire = 1'b1;
                    if (is_last) begin
                        state_nxt = S_IDLE;
                    end
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q   <= '0;
            base_q   <= '0;
            mask_q   <= '0;
            stride_q <= '0;
            len_q    <= '0;
            idx_q    <= '0;
            step_q   <= M_FIXED;
        end else if (cmd_fire) begin
            addr_q   <= bus.cmd_addr;
            base_q   <= bus.cmd_addr & ~wrap_mask;
            mask_q   <= wrap_mask;
            stride_q <= stride_ext;
            len_q    <= len_eff;
            idx_q    <= '0;
            step_q   <= step_sel;
        end else if (beat_fire) begin
            if (is_last) begin
                // addr_out keeps the final address; only the index rewinds.
                idx_q <= '0;
            end else begin
                idx_q  <= idx_q + ONE_LEN;
                addr_q <= addr_next;
            end
        end
    end

    assign bus.addr_out = addr_q;
    assign bus.beat_idx = idx_q;

`ifdef BURST_ADDR_GEN_DEBUG_EN
    logic cmd_illegal;

    assign cmd_illegal = (bus.cmd_len == '0) || (bus.cmd_len > MAX_LEN) ||
                         ((bus.cmd_mode == 2'b10) && !wrap_ok);

    always_ff @(posedge clk) begin
        if (rst) begin
            dbg_burst_cnt <= '0;
            dbg_err       <= 1'b0;
        end else begin
            if (beat_fire && is_last && (dbg_burst_cnt != 16'hFFFF)) begin
                dbg_burst_cnt <= dbg_burst_cnt + 16'd1;
            end
            if (cmd_fire && cmd_illegal) begin
                dbg_err <= 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_burst_addr_gen.sv
module tb_burst_addr_gen;
    localparam int AW = 32;
    localparam int LW = 5;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [LW-1:0] idx;
        logic          last;
    } beat_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;
    beat_t exp_q[$];

`ifdef BURST_ADDR_GEN_DEBUG_EN
    logic [15:0] dbg_burst_cnt;
    logic        dbg_err;
`endif

    always #5 clk = ~clk;

    burst_addr_gen_if #(.ADDR_WIDTH(32), .MAX_BURST_LEN(16), .STRIDE_WIDTH(8)) bus ();

    burst_addr_gen #(.ADDR_WIDTH(32), .MAX_BURST_LEN(16), .STRIDE_WIDTH(8)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
`ifdef BURST_ADDR_GEN_DEBUG_EN
        ,
        .dbg_burst_cnt(dbg_burst_cnt),
        .dbg_err(dbg_err)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push_beat(input logic [AW-1:0] a, input int idx, input bit last);
        beat_t b;
        b.addr = a;
        b.idx  = LW'(idx);
        b.last = last;
        exp_q.push_back(b);
    endtask

    // Called at a negedge; returns at the negedge after acceptance.
    task automatic send_cmd(input logic [AW-1:0] a, input logic [LW-1:0] len,
                            input logic [1:0] mode, input logic [7:0] stride);
        bus.cmd_valid  = 1'b1;
        bus.cmd_addr   = a;
        bus.cmd_len    = len;
        bus.cmd_mode   = mode;
        bus.cmd_stride = stride;
        chk("cmd_ready_idle", bus.cmd_ready, 1);
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        chk("valid_latency", bus.addr_valid, 1);
        chk("busy_in_burst", bus.busy, 1);
        chk("cmd_ready_busy", bus.cmd_ready, 0);
    endtask

    // Drives addr_ready, compares every presented beat against the queue head
    // (which also covers stability under backpressure) and pops on handshake.
    // stop_after >= 0 returns once that many beats are taken, with ready low.
    task automatic run_burst(input int stall_beat, input int stall_cycles, input int stop_after);
        int    got = 0;
        int    stalled = 0;
        int    cyc = 0;
        bit    done = 0;
        beat_t e;
        while (!done && cyc < 300) begin
            if (got == stop_after) begin
                bus.addr_ready = 1'b0;
                return;
            end
            if (got == stall_beat && stalled < stall_cycles) begin
                bus.addr_ready = 1'b0;
                stalled++;
            end else begin
                bus.addr_ready = 1'b1;
            end
            if (bus.addr_valid) begin
                checks++;
                assert (exp_q.size() != 0) else begin
                    errors++;
                    $error("FAIL sb_underflow: observed beat addr=0x%0h expected=none", bus.addr_out);
                end
                if (exp_q.size() == 0) begin
                    done = 1;
                end else begin
                    e = exp_q[0];
                    chk("addr_out", bus.addr_out, e.addr);
                    chk("beat_idx", 32'(bus.beat_idx), 32'(e.idx));
                    chk("addr_last", bus.addr_last, e.last);
                    if (bus.addr_ready) begin
                        void'(exp_q.pop_front());
                        got++;
                        if (e.last) done = 1;
                    end
                end
            end
            @(negedge clk);
            cyc++;
        end
        bus.addr_ready = 1'b0;
        checks++;
        assert (done) else begin
            errors++;
            $error("FAIL timeout: observed beats=%0d expected burst completion", got);
        end
        chk("idle_valid", bus.addr_valid, 0);
        chk("idle_cmd_ready", bus.cmd_ready, 1);
        chk("idle_busy", bus.busy, 0);
        chk("sb_empty", exp_q.size(), 0);
    endtask

    initial begin
        bus.cmd_valid  = 1'b0;
        bus.cmd_addr   = '0;
        bus.cmd_len    = '0;
        bus.cmd_mode   = 2'b00;
        bus.cmd_stride = '0;
        bus.addr_ready = 1'b0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        chk("rst_cmd_ready", bus.cmd_ready, 1);
        chk("rst_addr_valid", bus.addr_valid, 0);
        chk("rst_addr_out", bus.addr_out, 0);
        chk("rst_addr_last", bus.addr_last, 0);
        chk("rst_beat_idx", 32'(bus.beat_idx), 0);
        chk("rst_busy", bus.busy, 0);
`ifdef BURST_ADDR_GEN_DEBUG_EN
        chk("rst_dbg_cnt", dbg_burst_cnt, 0);
        chk("rst_dbg_err", dbg_err, 0);
`endif

        // INCR 0x100 len 4 stride 4
        push_beat(32'h100, 0, 0); push_beat(32'h104, 1, 0);
        push_beat(32'h108, 2, 0); push_beat(32'h10C, 3, 1);
        send_cmd(32'h100, 5'd4, 2'b01, 8'd4);
        run_burst(-1, 0, -1);

        // WRAP 0x108 len 4 stride 4
        push_beat(32'h108, 0, 0); push_beat(32'h10C, 1, 0);
        push_beat(32'h100, 2, 0); push_beat(32'h104, 3, 1);
        send_cmd(32'h108, 5'd4, 2'b10, 8'd4);
        run_burst(-1, 0, -1);

        // FIXED 0x200 len 3
        push_beat(32'h200, 0, 0); push_beat(32'h200, 1, 0); push_beat(32'h200, 2, 1);
        send_cmd(32'h200, 5'd3, 2'b00, 8'd4);
        run_burst(-1, 0, -1);

        // INCR rolling over the top of the address space
        push_beat(32'hFFFF_FFFC, 0, 0); push_beat(32'h0000_0000, 1, 1);
        send_cmd(32'hFFFF_FFFC, 5'd2, 2'b01, 8'd4);
        run_burst(-1, 0, -1);

        // Backpressure: beat 1 held for 3 cycles
        push_beat(32'h300, 0, 0); push_beat(32'h308, 1, 0);
        push_beat(32'h310, 2, 0); push_beat(32'h318, 3, 1);
        send_cmd(32'h300, 5'd4, 2'b01, 8'd8);
        run_burst(1, 3, -1);

        // Reset while beat 2 of a len-8 burst is presented
        for (int k = 0; k < 8; k++) push_beat(32'h1000 + 32'(k), k, k == 7);
        send_cmd(32'h1000, 5'd8, 2'b01, 8'd1);
        run_burst(-1, 0, 2);
        chk("pre_rst_beat_idx", 32'(bus.beat_idx), 2);
        exp_q.delete();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_valid", bus.addr_valid, 0);
        chk("abort_busy", bus.busy, 0);
        chk("abort_cmd_ready", bus.cmd_ready, 1);
        chk("abort_addr_out", bus.addr_out, 0);
        chk("abort_beat_idx", 32'(bus.beat_idx), 0);

        // Clean restart after the abort
        push_beat(32'h40, 0, 0); push_beat(32'h42, 1, 1);
        send_cmd(32'h40, 5'd2, 2'b01, 8'd2);
        run_burst(-1, 0, -1);
`ifdef BURST_ADDR_GEN_DEBUG_EN
        chk("dbg_cnt_after_restart", dbg_burst_cnt, 1);
        chk("dbg_err_legal", dbg_err, 0);
`endif

        // len 0 runs as one beat
        push_beat(32'h500, 0, 1);
        send_cmd(32'h500, 5'd0, 2'b01, 8'd4);
        run_burst(-1, 0, -1);
`ifdef BURST_ADDR_GEN_DEBUG_EN
        chk("dbg_cnt_len0", dbg_burst_cnt, 2);
        chk("dbg_err_len0", dbg_err, 1);
`endif

        // len 20 clamps to 16; reserved mode 11 runs as INCR
        for (int k = 0; k < 16; k++) push_beat(32'hABC0 + 32'(k), k, k == 15);
        send_cmd(32'hABC0, 5'd20, 2'b11, 8'd1);
        run_burst(-1, 0, -1);

        // WRAP with non-power-of-two length falls back to INCR
        push_beat(32'h108, 0, 0); push_beat(32'h10C, 1, 0); push_beat(32'h110, 2, 1);
        send_cmd(32'h108, 5'd3, 2'b10, 8'd4);
        run_burst(-1, 0, -1);

        // Stride 0 in INCR holds the address
        push_beat(32'h700, 0, 0); push_beat(32'h700, 1, 1);
        send_cmd(32'h700, 5'd2, 2'b01, 8'd0);
        run_burst(-1, 0, -1);

        // WRAP len 8 stride 2 from 0x3C: 16-byte window at 0x30
        for (int k = 0; k < 8; k++) push_beat(32'h30 | ((32'hC + 32'(2 * k)) & 32'hF), k, k == 7);
        send_cmd(32'h3C, 5'd8, 2'b10, 8'd2);
        run_burst(-1, 0, -1);
`ifdef BURST_ADDR_GEN_DEBUG_EN
        chk("dbg_cnt_end", dbg_burst_cnt, 6);
        chk("dbg_err_sticky", dbg_err, 1);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
